// File: rtl/pacman_pkg.sv
// Shared Pac-Man types: sprite coordinates, tile geometry and the collision FSM states.
package pacman_pkg;

  typedef logic [9:0] coord_t;

  localparam int TILE_WIDTH  = 8;
  localparam int TILE_HEIGHT = 8;
  localparam int SPRITE_SIZE = 16;

  typedef enum logic [1:0] {PLAY, HIT, RESPAWN, GAME_OVER} collide_state_t;

  // 11-bit difference keeps the sign of a 10-bit subtraction, so no wrap.
  function automatic logic [10:0] abs_diff11(input coord_t a, input coord_t b);
    logic [10:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[10] ? (11'd0 - d) : d;
  endfunction

endpackage

// File: rtl/sprite_overlap.sv
// Pure-combinational proximity test between two sprite centres.
module sprite_overlap
  import pacman_pkg::*;
#(
  parameter int HIT_DIST = 8
) (
  input  coord_t ax_i,
  input  coord_t ay_i,
  input  coord_t bx_i,
  input  coord_t by_i,
  output logic   hit_o
);

  localparam logic [10:0] HD = 11'(HIT_DIST);

  logic [10:0] dx, dy;

  assign dx    = abs_diff11(ax_i, bx_i);
  assign dy    = abs_diff11(ay_i, by_i);
  assign hit_o = (dx < HD) && (dy < HD);

endmodule

// File: rtl/ghost_collision_ctrl.sv
// Per-frame ghost/Pac-Man contact check, lives bookkeeping and death/respawn/game-over sequencing.
// Optional FRIGHTENED_MODE_EN adds the power-pellet fright timer and ghost_eaten pulses.
module ghost_collision_ctrl
  import pacman_pkg::*;
#(
  parameter int NUM_GHOSTS    = 4,
  parameter int HIT_DIST      = 8,
  parameter int START_LIVES   = 3,
`ifdef FRIGHTENED_MODE_EN
  parameter int FRIGHT_FRAMES = 360,
`endif
  parameter int DEATH_FRAMES  = 60
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [9:0]              PacmanX,
  input  logic [9:0]              PacmanY,
  input  logic [NUM_GHOSTS*10-1:0] GhostX,
  input  logic [NUM_GHOSTS*10-1:0] GhostY,
`ifdef FRIGHTENED_MODE_EN
  input  logic                    power_pellet,
  output logic                    frightened,
  output logic [NUM_GHOSTS-1:0]   ghost_eaten,
`endif
  output logic                    freeze,
  output logic                    respawn,
  output logic                    game_over,
  output logic [2:0]              lives,
  output logic [(NUM_GHOSTS>1 ? $clog2(NUM_GHOSTS) : 1)-1:0] hit_ghost
);

  localparam int GW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
  localparam int DW = $clog2(DEATH_FRAMES + 1);

  collide_state_t        state_q, state_d;
  logic [2:0]            lives_q, lives_d;
  logic                  freeze_q, freeze_d;
  logic                  respawn_q, respawn_d;
  logic                  game_over_q, game_over_d;
  logic [GW-1:0]         hit_ghost_q, hit_ghost_d;
  logic [DW-1:0]         death_q, death_d;
  logic [NUM_GHOSTS-1:0] contact;
  logic [GW-1:0]         first_idx;
  logic                  eat;

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ov
    sprite_overlap #(.HIT_DIST(HIT_DIST)) u_ov (
      .ax_i (PacmanX),
      .ay_i (PacmanY),
      .bx_i (GhostX[10*g +: 10]),
      .by_i (GhostY[10*g +: 10]),
      .hit_o(contact[g])
    );
  end

  // Scan downwards so the lowest contacting index wins.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_GHOSTS - 1; i >= 0; i--)
      if (contact[i]) first_idx = GW'(i);
  end

`ifdef FRIGHTENED_MODE_EN
  localparam int FW = $clog2(FRIGHT_FRAMES + 1);
  logic [FW-1:0]         fright_q, fright_d;
  logic [NUM_GHOSTS-1:0] eaten_q, eaten_d;

  // A pellet on the same edge as a contact already protects Pac-Man.
  assign eat         = power_pellet | (fright_q != '0);
  assign frightened  = (fright_q != '0);
  assign ghost_eaten = eaten_q;
`else
  assign eat = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    freeze_d    = freeze_q;
    respawn_d   = 1'b0;
    game_over_d = game_over_q;
    hit_ghost_d = hit_ghost_q;
    death_d     = death_q;
`ifdef FRIGHTENED_MODE_EN
    fright_d    = fright_q;
    eaten_d     = '0;
`endif
    case (state_q)
      PLAY: begin
        freeze_d = 1'b0;
`ifdef FRIGHTENED_MODE_EN
        if (power_pellet)         fright_d = FW'(FRIGHT_FRAMES);
        else if (fright_q != '0)  fright_d = fright_q - 1'b1;
        if (eat) eaten_d = contact;
`endif
        if ((|contact) && !eat) begin
          state_d     = HIT;
          if (lives_q != '0) lives_d = lives_q - 1'b1;
          freeze_d    = 1'b1;
          hit_ghost_d = first_idx;
          death_d     = '0;
`ifdef FRIGHTENED_MODE_EN
          fright_d    = '0;
`endif
        end
      end
      HIT: begin
        freeze_d = 1'b1;
        if (death_q == DW'(DEATH_FRAMES - 1)) begin
          if (lives_q == '0) begin
            state_d     = GAME_OVER;
            game_over_d = 1'b1;
          end else begin
            state_d   = RESPAWN;
            respawn_d = 1'b1;
          end
        end else begin
          death_d = death_q + 1'b1;
        end
      end
      RESPAWN: begin
        state_d  = PLAY;
        freeze_d = 1'b0;
      end
      default: begin
        freeze_d    = 1'b1;
        game_over_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= PLAY;
      lives_q     <= 3'(START_LIVES);
      freeze_q    <= 1'b0;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
      hit_ghost_q <= '0;
      death_q     <= '0;
`ifdef FRIGHTENED_MODE_EN
      fright_q    <= '0;
      eaten_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      freeze_q    <= freeze_d;
      respawn_q   <= respawn_d;
      game_over_q <= game_over_d;
      hit_ghost_q <= hit_ghost_d;
      death_q     <= death_d;
`ifdef FRIGHTENED_MODE_EN
      fright_q    <= fright_d;
      eaten_q     <= eaten_d;
`endif
    end
  end

  assign freeze    = freeze_q;
  assign respawn   = respawn_q;
  assign game_over = game_over_q;
  assign lives     = lives_q;
  assign hit_ghost = hit_ghost_q;

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Bench for ghost_collision_ctrl: frame-level model plus directed death/respawn/game-over scenarios.
module tb_ghost_collision_ctrl;
  localparam int NG = 4;
  localparam int DF = 60;
  localparam int FF = 360;
  localparam int HD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  px, py;
  logic [NG*10-1:0] gx, gy;
  logic        pellet;
  logic        freeze, respawn, game_over;
  logic [2:0]  lives;
  logic [1:0]  hit_ghost;
`ifdef FRIGHTENED_MODE_EN
  logic        frightened;
  logic [NG-1:0] ghost_eaten;
`endif

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  ghost_collision_ctrl dut (
    .frame_clk(clk),
    .Reset    (rst),
    .PacmanX  (px),
    .PacmanY  (py),
    .GhostX   (gx),
    .GhostY   (gy),
`ifdef FRIGHTENED_MODE_EN
    .power_pellet(pellet),
    .frightened  (frightened),
    .ghost_eaten (ghost_eaten),
`endif
    .freeze   (freeze),
    .respawn  (respawn),
    .game_over(game_over),
    .lives    (lives),
    .hit_ghost(hit_ghost)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit touching(input int g);
    int dx, dy;
    dx = int'(px) - int'(gx[10*g +: 10]);
    dy = int'(py) - int'(gy[10*g +: 10]);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx < HD) && (dy < HD);
  endfunction

  // Frame-level model: mode 0 play, 1 dying, 2 respawning, 3 over.
  int m_st = 0, m_lives = 3, m_freeze = 0, m_resp = 0, m_go = 0, m_hg = 0;
  int m_left = 0, m_fr = 0, m_eat = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_lives = 3; m_freeze = 0; m_resp = 0; m_go = 0; m_hg = 0;
      m_left = 0; m_fr = 0; m_eat = 0;
    end else begin
      int low, mask;
      bit scared;
      m_resp = 0;
      m_eat  = 0;
      case (m_st)
        0: begin
          low = -1; mask = 0; scared = 1'b0;
          for (int g = NG - 1; g >= 0; g--)
            if (touching(g)) begin low = g; mask |= (1 << g); end
`ifdef FRIGHTENED_MODE_EN
          scared = pellet || (m_fr > 0);
          if (pellet) m_fr = FF;
          else if (m_fr > 0) m_fr--;
`endif
          if (low >= 0) begin
            if (scared) m_eat = mask;
            else begin
              m_st = 1; m_lives--; m_freeze = 1; m_hg = low; m_left = DF; m_fr = 0;
            end
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            if (m_lives == 0) begin m_st = 3; m_go = 1; end
            else begin m_st = 2; m_resp = 1; end
          end
        end
        2: begin m_st = 0; m_freeze = 0; end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("lives", int'(lives), m_lives);
      chk("freeze", int'(freeze), m_freeze);
      chk("respawn", int'(respawn), m_resp);
      chk("game_over", int'(game_over), m_go);
      chk("hit_ghost", int'(hit_ghost), m_hg);
`ifdef FRIGHTENED_MODE_EN
      chk("frightened", int'(frightened), int'(m_fr != 0));
      chk("ghost_eaten", int'(ghost_eaten), m_eat);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ghost(input int g, input int x, input int y);
    gx[10*g +: 10] = 10'(x);
    gy[10*g +: 10] = 10'(y);
  endtask

  task automatic set_pac(input int x, input int y);
    px = 10'(x);
    py = 10'(y);
  endtask

  // Observe samples after a HIT entry; returns first respawn sample index and pulse count.
  task automatic wait_resp(output int first, output int n);
    first = -1;
    n = 0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (respawn) begin
        n++;
        if (first < 0) first = k;
      end
      if (first >= 0 && k == first + 1) chk("freeze_after_respawn", int'(freeze), 0);
    end
  endtask

  int fr_cnt = 0;
  bit count_fr = 1'b0;
`ifdef FRIGHTENED_MODE_EN
  always @(negedge clk) if (count_fr && frightened) fr_cnt++;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, n, bad;
    rst = 1'b1; pellet = 1'b0;
    gx = '0; gy = '0;
    set_ghost(0, 328, 248);
    set_ghost(1, 100, 100);
    set_ghost(2, 600, 400);
    set_ghost(3, 50, 450);
    set_pac(424, 360);
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_lives", int'(lives), 3);
    chk("reset_freeze", int'(freeze), 0);
    chk("reset_game_over", int'(game_over), 0);
    chk("reset_hit_ghost", int'(hit_ghost), 0);

    step(10);
    @(negedge clk);
    chk("idle_lives", int'(lives), 3);
    chk("idle_freeze", int'(freeze), 0);

    set_pac(336, 248);  // dx = 8: just outside
    step(3);
    @(negedge clk);
    chk("dx8_freeze", int'(freeze), 0);
    chk("dx8_lives", int'(lives), 3);

    set_pac(335, 248);  // dx = 7: contact
    step(1);
    set_pac(424, 360);
    @(negedge clk);
    chk("death1_lives", int'(lives), 2);
    chk("death1_freeze", int'(freeze), 1);
    chk("death1_hit_ghost", int'(hit_ghost), 0);
    wait_resp(first, n);
    chk("death1_resp_delay", first, DF);
    chk("death1_resp_count", n, 1);

    set_ghost(1, 200, 200);
    set_ghost(3, 204, 196);
    set_pac(200, 200);
    step(1);
    set_pac(424, 360);
    @(negedge clk);
    chk("death2_hit_ghost", int'(hit_ghost), 1);
    chk("death2_lives", int'(lives), 1);
    wait_resp(first, n);
    chk("death2_resp_delay", first, DF);
    chk("death2_resp_count", n, 1);

    set_pac(600, 400);  // stay on ghost 2
    step(1);
    @(negedge clk);
    chk("death3_lives", int'(lives), 0);
    chk("death3_hit_ghost", int'(hit_ghost), 2);
    repeat (DF - 1) @(negedge clk);
    chk("go_not_yet", int'(game_over), 0);
    @(negedge clk);
    chk("go_set", int'(game_over), 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!(game_over && freeze && lives == 3'd0 && !respawn)) bad++;
    end
    chk("go_hold_100", bad, 0);

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    set_pac(328, 248);
    @(negedge clk);
    chk("rst2_lives", int'(lives), 3);
    chk("rst2_game_over", int'(game_over), 0);
    step(1);
    set_pac(424, 360);
    step(30);  // death count now 30
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midhit_lives", int'(lives), 3);
    chk("midhit_freeze", int'(freeze), 0);
    chk("midhit_hit_ghost", int'(hit_ghost), 0);
    n = 0;
    repeat (80) begin
      @(negedge clk);
      if (respawn || freeze) n++;
    end
    chk("midhit_stays_play", n, 0);

`ifdef FRIGHTENED_MODE_EN
    count_fr = 1'b1;
    pellet = 1'b1;
    step(1);
    pellet = 1'b0;
    step(10);
    set_pac(600, 400);
    step(1);
    set_pac(424, 360);
    @(negedge clk);
    chk("eat_mask", int'(ghost_eaten), 4);
    chk("eat_lives", int'(lives), 3);
    @(negedge clk);
    chk("eat_pulse_end", int'(ghost_eaten), 0);
    for (int k = 0; k < 400 && frightened; k++) @(negedge clk);
    chk("fright_frames", fr_cnt, FF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
